uart_rx: RTL and testbench



---
 rtl/uart_rx_if.sv | 19 +
 rtl/uart_rx.sv | 105 ++++++++++
 tb/tb_uart_rx.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Serial receive bundle: the line into the receiver plus its byte/status outputs.
// The master drives the line and the slave is the receiver.
interface uart_rx_if;
  logic       uart_rx;
  logic [7:0] uart_data_rx;
  logic       uart_valid;
  logic       uart_frame_err;
  logic       uart_busy;

  modport master (
    output uart_rx,
    input  uart_data_rx, uart_valid, uart_frame_err, uart_busy
  );

  modport slave (
    input  uart_rx,
    output uart_data_rx, uart_valid, uart_frame_err, uart_busy
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, with mid-bit sampling.
// Good bytes pulse uart_valid, and frames whose stop bit is low pulse uart_frame_err.
module uart_rx #(
  parameter int CLKS_PER_BIT = 100
) (
  input  logic     sys_clk,
  input  logic     sys_rst,
  uart_rx_if.slave bus
);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic          rx_meta_q, rx_s_q, rx_d_q;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_d_q    <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rx_meta_q <= bus.uart_rx;
      rx_s_q    <= rx_meta_q;
      rx_d_q    <= rx_s_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // Only a high-to-low transition starts a frame, so a stuck-low line never retriggers.
        if (rx_d_q && !rx_s_q) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == BIT_M1) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == BIT_M1) begin
          // Leaving at mid stop bit gives half a bit of slack for back-to-back frames.
          cnt_d   = '0;
          state_d = IDLE;
          if (rx_s_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ferr_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.uart_data_rx   = data_q;
  assign bus.uart_valid     = valid_q;
  assign bus.uart_frame_err = ferr_q;
  assign bus.uart_busy      = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Randomised bench for uart_rx with two instances, N=100 and N=8, checked against a
// frame-level model that gives the expected bytes and timing from the sent frames.
module tb_uart_rx;
  localparam int N  = 100;
  localparam int N8 = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_rx_if bus100 ();
  uart_rx_if bus8 ();
  logic line100 = 1'b1;
  logic line8   = 1'b1;
  assign bus100.uart_rx = line100;
  assign bus8.uart_rx   = line8;

  uart_rx #(.CLKS_PER_BIT(N))  dut100 (.sys_clk(clk), .sys_rst(rst), .bus(bus100));
  uart_rx #(.CLKS_PER_BIT(N8)) dut8   (.sys_clk(clk), .sys_rst(rst), .bus(bus8));

  int checks = 0;
  int errors = 0;

  // Observation side: record every pulse on the falling edge.
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  rxq100[$];
  logic [7:0]  rxq8[$];
  int unsigned vcyc100[$];
  int ferr100 = 0, ferr8 = 0, busy100 = 0, both_seen = 0;
  int unsigned last_fall = 0;

  always @(negedge clk) begin
    if (bus100.uart_valid) begin
      rxq100.push_back(bus100.uart_data_rx);
      vcyc100.push_back(cyc);
    end
    if (bus100.uart_frame_err) ferr100++;
    if (bus100.uart_busy) busy100++;
    if (bus8.uart_valid) rxq8.push_back(bus8.uart_data_rx);
    if (bus8.uart_frame_err) ferr8++;
    if ((bus100.uart_valid && bus100.uart_frame_err) || (bus8.uart_valid && bus8.uart_frame_err))
      both_seen++;
  end

  task automatic drive(input bit sel8, input logic v);
    if (sel8) line8 = v;
    else      line100 = v;
  endtask

  task automatic send_frame(input bit sel8, input logic [7:0] b, input int bl, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    last_fall = cyc;
    for (int i = 0; i < 10; i++) begin
      drive(sel8, bits[i]);
      repeat (bl) @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    line100 = 1'b1;
    line8   = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_single(input string name, input logic [7:0] exp);
    checks++;
    if (rxq100.size() != 1) begin
      errors++;
      $display("FAIL %s_count: got %0d pulses, expected 1", name, rxq100.size());
    end else begin
      checks++;
      if (rxq100[0] !== exp) begin
        errors++;
        $display("FAIL %s_data: got %h expected %h", name, rxq100[0], exp);
      end
    end
    checks++;
    if (bus100.uart_data_rx !== exp) begin
      errors++;
      $display("FAIL %s_held: got %h expected %h", name, bus100.uart_data_rx, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if ({bus100.uart_data_rx, bus100.uart_valid, bus100.uart_frame_err, bus100.uart_busy} !== 11'h0) begin
      errors++;
      $display("FAIL reset_100: got data=%h v=%b fe=%b busy=%b expected all zero",
               bus100.uart_data_rx, bus100.uart_valid, bus100.uart_frame_err, bus100.uart_busy);
    end
    checks++;
    if ({bus8.uart_data_rx, bus8.uart_valid, bus8.uart_frame_err, bus8.uart_busy} !== 11'h0) begin
      errors++;
      $display("FAIL reset_8: got data=%h v=%b fe=%b busy=%b expected all zero",
               bus8.uart_data_rx, bus8.uart_valid, bus8.uart_frame_err, bus8.uart_busy);
    end
    rst = 1'b0;
    idle(20);
  endtask

  task automatic test_single();
    int f0;
    rxq100.delete();
    vcyc100.delete();
    f0 = ferr100;
    send_frame(1'b0, 8'h55, N, 1'b1);
    idle(2 * N);
    check_single("single55", 8'h55);
    // Low reaches rx_s at fall+2, detection at fall+3, and valid is seen one cycle after the stop-sample edge.
    checks++;
    if (vcyc100.size() == 1 && vcyc100[0] != last_fall + 3 + N / 2 + 9 * N) begin
      errors++;
      $display("FAIL single55_latency: got %0d cycles expected %0d",
               vcyc100[0] - last_fall, 3 + N / 2 + 9 * N);
    end
    checks++;
    if (ferr100 != f0 || bus100.uart_busy !== 1'b0) begin
      errors++;
      $display("FAIL single55_status: got ferr_delta=%0d busy=%b expected 0 and 0",
               ferr100 - f0, bus100.uart_busy);
    end
  endtask

  task automatic test_back_to_back();
    rxq100.delete();
    vcyc100.delete();
    send_frame(1'b0, 8'hA5, N, 1'b1);
    send_frame(1'b0, 8'h3C, N, 1'b1);
    idle(2 * N);
    checks++;
    if (rxq100.size() != 2) begin
      errors++;
      $display("FAIL b2b_count: got %0d expected 2", rxq100.size());
    end else begin
      checks++;
      if (rxq100[0] !== 8'hA5 || rxq100[1] !== 8'h3C) begin
        errors++;
        $display("FAIL b2b_data: got %h %h expected a5 3c", rxq100[0], rxq100[1]);
      end
      checks++;
      if (vcyc100[1] - vcyc100[0] != 10 * N) begin
        errors++;
        $display("FAIL b2b_spacing: got %0d expected %0d", vcyc100[1] - vcyc100[0], 10 * N);
      end
    end
  endtask

  task automatic test_glitch();
    int b0, f0;
    rxq100.delete();
    b0 = busy100;
    f0 = ferr100;
    line100 = 1'b0;
    repeat (20) @(negedge clk);
    idle(3 * N);
    checks++;
    if (busy100 - b0 != N / 2) begin
      errors++;
      $display("FAIL glitch_busy: got %0d busy cycles expected %0d", busy100 - b0, N / 2);
    end
    checks++;
    if (rxq100.size() != 0 || ferr100 != f0) begin
      errors++;
      $display("FAIL glitch_pulse: got valid=%0d ferr=%0d expected 0 and 0", rxq100.size(), ferr100 - f0);
    end
    send_frame(1'b0, 8'h81, N, 1'b1);
    idle(2 * N);
    check_single("glitch_next81", 8'h81);
  endtask

  task automatic test_frame_error();
    int b0, f0;
    rxq100.delete();
    f0 = ferr100;
    send_frame(1'b0, 8'hC3, N, 1'b0);
    b0 = busy100;
    repeat (3 * N) @(negedge clk);
    checks++;
    if (busy100 != b0) begin
      errors++;
      $display("FAIL ferr_retrigger: got %0d busy cycles while low expected 0", busy100 - b0);
    end
    idle(2 * N);
    checks++;
    if (ferr100 - f0 != 1 || rxq100.size() != 0) begin
      errors++;
      $display("FAIL ferr_pulse: got ferr=%0d valid=%0d expected 1 and 0", ferr100 - f0, rxq100.size());
    end
    checks++;
    if (bus100.uart_data_rx !== 8'h81) begin
      errors++;
      $display("FAIL ferr_data_kept: got %h expected 81", bus100.uart_data_rx);
    end
    send_frame(1'b0, 8'h18, N, 1'b1);
    idle(2 * N);
    check_single("ferr_next18", 8'h18);
  endtask

  task automatic test_reset_midframe();
    int f0;
    rxq100.delete();
    f0 = ferr100;
    line100 = 1'b0;
    repeat (N) @(negedge clk);
    line100 = 1'b1;
    repeat (4 * N + N / 2) @(negedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({bus100.uart_data_rx, bus100.uart_valid, bus100.uart_frame_err, bus100.uart_busy} !== 11'h0) begin
      errors++;
      $display("FAIL rst_async: got data=%h v=%b fe=%b busy=%b expected all zero",
               bus100.uart_data_rx, bus100.uart_valid, bus100.uart_frame_err, bus100.uart_busy);
    end
    @(negedge clk);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (N / 2 + 4 * N - 6) @(negedge clk);
    idle(2 * N);
    checks++;
    if (rxq100.size() != 0 || ferr100 != f0 || bus100.uart_busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_no_pulse: got valid=%0d ferr=%0d busy=%b expected 0 0 0",
               rxq100.size(), ferr100 - f0, bus100.uart_busy);
    end
    send_frame(1'b0, 8'h42, N, 1'b1);
    idle(2 * N);
    check_single("rst_next42", 8'h42);
  endtask

  task automatic test_tolerance(input int bl);
    logic [7:0] b;
    for (int i = 0; i < 6; i++) begin
      rxq100.delete();
      b = 8'($urandom);
      send_frame(1'b0, b, bl, 1'b1);
      idle($urandom_range(200, 10));
      checks++;
      if (rxq100.size() != 1 || rxq100[0] !== b) begin
        errors++;
        $display("FAIL tol%0d_byte%0d: got %0d pulses first=%h expected one of %h",
                 bl, i, rxq100.size(), (rxq100.size() > 0) ? rxq100[0] : 8'hxx, b);
      end
    end
  endtask

  task automatic test_n8();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int f0;
    rxq8.delete();
    f0 = ferr8;
    for (int i = 0; i < 20; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      send_frame(1'b1, b, N8, 1'b1);
      if ($urandom_range(1, 0) == 1) idle($urandom_range(30, 1));
    end
    idle(4 * N8);
    checks++;
    if (rxq8.size() != exp_q.size() || ferr8 != f0) begin
      errors++;
      $display("FAIL n8_count: got %0d bytes ferr=%0d expected %0d bytes ferr=0",
               rxq8.size(), ferr8 - f0, exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (rxq8[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL n8_byte%0d: got %h expected %h", i, rxq8[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_exclusive();
    checks++;
    if (both_seen != 0) begin
      errors++;
      $display("FAIL exclusive: got %0d cycles with valid and frame_err together expected 0", both_seen);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_reset_midframe();
    test_tolerance(104);
    test_tolerance(96);
    test_n8();
    test_exclusive();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
